therm_ramp_decoder: RTL and testbench
=====================================

# therm_ramp_decoder

Binary-to-thermometer decoder with a controlled ramp: accepts a 4-bit target level over a valid/ready handshake and drives a 15-bit thermometer code that walks one bit per step from the current level to the target. It is the decode-side counterpart of the 15-to-4 thermometer encoder. It sits between the control logic and thermometer-driven loads that must not see multi-bit jumps, such as segmented DAC switches or LED bars.

## Interface
- `STEP_CYCLES`, default 1: clock cycles per one-bit step; legal range 1..255.
- `BIN_W`, default 4: width of the binary level.
- `THERM_W`, default 15: thermometer width; must equal 2^BIN_W − 1.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: target present on `in_code`.
- `in_ready`  out  1: block can accept a target.
- `in_code`  in  BIN_W: target level, 0..15.
- `therm`  out  THERM_W: thermometer code. Bits [level−1:0] are 1, all others 0.
- `level`  out  BIN_W: current level, equal to popcount(`therm`).
- `busy`  out  1: ramp in progress.
- `done`  out  1: one-cycle pulse when `level` reaches the target.
- `abort`  in  1: present only with `THERM_ABORT_EN`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RAMP: `busy`=1.
  - DONE: `done`=1 for one cycle.
- Reset values: state IDLE, `therm`=0, `level`=0, `busy`=0, `done`=0, `in_ready`=1 from the first cycle after reset.
- Accept happens when `in_valid` && `in_ready` at an edge. The block latches `target`=`in_code` and clears the step counter.
  - If `target`≠`level`, it goes to RAMP.
  - If `target`==`level`, it goes straight to DONE and `therm` is unchanged.
- In RAMP, at each edge:
  - If the step counter equals STEP_CYCLES−1, the block takes one step and clears the counter. Otherwise the counter increments.
  - Step up (`target`>`level`): set `therm[level]`, then `level`+1.
  - Step down (`target`<`level`): clear `therm[level−1]`, then `level`−1.
- When a step makes `level`==`target`, the block moves to DONE on the same edge. DONE always returns to IDLE after one cycle.
- `in_valid` is ignored in RAMP and DONE. The upstream must hold `in_valid` until it sees `in_ready`. Nothing is queued.
- Exactly one bit of `therm` changes per step. `therm` never jumps by more than one bit.
- `level` stays in 0..15. Underflow and overflow are impossible by construction.
- `rst` in any state, including mid-ramp, forces the reset values on the next edge. `rst` has priority over the handshake and over `abort`.

## Timing
- Accept at edge E0:
  - First `therm` change at edge E0+STEP_CYCLES.
  - Last change at E0+|d|·STEP_CYCLES, where d = target − initial level.
  - `done` is high in the cycle after the last change.
  - `in_ready` returns at E0+|d|·STEP_CYCLES+1.
- `in_ready` is low from the cycle after accept until DONE finishes.
- Equal-target accept: `done` is high in the cycle after E0, and `in_ready` is high again one cycle later.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- Throughput: back-to-back accepts are possible every |d|·STEP_CYCLES+2 cycles.

## Configuration
- `THERM_ABORT_EN` defined: the `abort` input exists.
  - `abort`=1 in RAMP freezes `therm` and `level` at their current values and moves to IDLE on the next edge.
  - No `done` pulse is produced.
  - A step that would coincide with `abort` on the same edge is suppressed.
  - `abort` in IDLE or DONE has no effect.
- `THERM_ABORT_EN` undefined: no `abort` port, and every ramp runs to completion.

## Structure
- Package `therm_pkg` holds:
  - The state enum (IDLE, RAMP, DONE).
  - Constants BIN_W=4 and THERM_W=15.
  - A function `bin2therm(level)` for checkers.
- Sub-module `therm_step_timer`: the STEP_CYCLES prescaler, with a clear input and a one-cycle `tick` output. The top module holds the FSM and the `therm`/`level` registers.

## Test plan
- Reset then idle: `therm`=0, `level`=0, `in_ready`=1, `done`=0. A `rst` pulse mid-ramp at `level`=7 gives `therm`=0 on the next edge.
- Up-ramp, STEP_CYCLES=1, level 0 → 15:
  - `therm` goes 0x0001, 0x0003, … 0x7FFF on 15 consecutive edges.
  - `done` is high at the 16th cycle after accept.
- Down-ramp, level 15 → 3:
  - Bits clear one at a time, from `therm[14]` down to `therm[3]`.
  - Final `therm`=0x0007 and `level`=3.
- Equal target, level 5 → 5: `therm` stays 0x001F, `done` pulses in the cycle after accept, and `busy` never rises.
- STEP_CYCLES=3, 2 → 4: changes occur at E0+3 and E0+6, and `in_valid` asserted mid-ramp is ignored.
- With `THERM_ABORT_EN`, 0 → 10 with `abort` after 4 steps: `therm` holds 0x000F, the block returns to IDLE, and there is no `done`.

Source files
------------

// File: rtl/therm_pkg.sv
// Shared types and constants for the thermometer ramp decoder.
package therm_pkg;

    localparam int unsigned BIN_W   = 4;
    localparam int unsigned THERM_W = 15;
    // Step prescaler width; STEP_CYCLES is limited to 1..255.
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference thermometer code for a level: bits [lvl-1:0] set.
    function automatic logic [THERM_W-1:0] bin2therm(input logic [BIN_W-1:0] lvl);
        logic [THERM_W:0] w_one;
        w_one = (THERM_W+1)'(1) << lvl;
        return THERM_W'(w_one - (THERM_W+1)'(1));
    endfunction

endpackage

// File: rtl/therm_step_timer.sv
// Step prescaler: o_tick_c fires once every STEP_CYCLES enabled cycles.
// o_tick_c is decoded from the counter register and the enable/clear inputs.
module therm_step_timer
    import therm_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last   = (r_cnt == LAST);
    assign o_tick_c = i_en && w_last && !i_clear;

    // Count enabled cycles, wrapping on the step boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/therm_ramp_decoder.sv
// Binary-to-thermometer decoder that walks one bit per step toward the target.
// Optional feature macro: THERM_ABORT_EN adds the abort input.
module therm_ramp_decoder
#(
    parameter int unsigned STEP_CYCLES = 1,
    parameter int unsigned BIN_W       = therm_pkg::BIN_W,
    parameter int unsigned THERM_W     = therm_pkg::THERM_W
) (
    input  logic               clk,
    input  logic               rst,
`ifdef THERM_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIN_W-1:0]   in_code,
    output logic [THERM_W-1:0] therm,
    output logic [BIN_W-1:0]   level,
    output logic               busy,
    output logic               done
);

    import therm_pkg::state_t;
    import therm_pkg::IDLE;
    import therm_pkg::RAMP;
    import therm_pkg::DONE;

    state_t             r_state;
    logic [THERM_W-1:0] r_therm;
    logic [BIN_W-1:0]   r_level;
    logic [BIN_W-1:0]   r_target;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_ramp;
    logic               w_tick;
    logic               w_abort;
    logic               w_up;
    logic [BIN_W-1:0]   w_level_inc;
    logic [BIN_W-1:0]   w_level_dec;
    logic [BIN_W-1:0]   w_level_next;

`ifdef THERM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept     = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_ramp       = (r_state == RAMP);
    assign w_up         = (r_target > r_level);
    assign w_level_inc  = r_level + BIN_W'(1);
    assign w_level_dec  = r_level - BIN_W'(1);
    assign w_level_next = w_up ? w_level_inc : w_level_dec;

    therm_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_en     (w_ramp),
        .o_tick_c (w_tick)
    );

    // Control FSM plus thermometer/level registers; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_therm    <= '0;
            r_level    <= '0;
            r_target   <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_target   <= in_code;
                        r_in_ready <= 1'b0;
                        if (in_code == r_level) begin
                            // Already there: report completion without touching therm.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RAMP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (w_abort) begin
                        // Freeze at the current level; a coincident step is dropped.
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (w_tick) begin
                        if (w_up) begin
                            r_therm[r_level]     <= 1'b1;
                        end else begin
                            r_therm[w_level_dec] <= 1'b0;
                        end
                        r_level <= w_level_next;
                        if (w_level_next == r_target) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign therm    = r_therm;
    assign level    = r_level;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_therm_ramp_decoder.sv
// Directed bench for therm_ramp_decoder with STEP_CYCLES=1 and STEP_CYCLES=3 instances.
module tb_therm_ramp_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v1, v3;
    logic [3:0]  c1, c3;
    logic        rdy1, rdy3;
    logic [14:0] th1, th3;
    logic [3:0]  lv1, lv3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic        ab1;

    int n_vec = 0;
    int n_err = 0;

    therm_ramp_decoder #(.STEP_CYCLES(1)) u1 (
        .clk      (clk),
        .rst      (rst),
`ifdef THERM_ABORT_EN
        .abort    (ab1),
`endif
        .in_valid (v1),
        .in_ready (rdy1),
        .in_code  (c1),
        .therm    (th1),
        .level    (lv1),
        .busy     (busy1),
        .done     (done1)
    );

    therm_ramp_decoder #(.STEP_CYCLES(3)) u3 (
        .clk      (clk),
        .rst      (rst),
`ifdef THERM_ABORT_EN
        .abort    (1'b0),
`endif
        .in_valid (v3),
        .in_ready (rdy3),
        .in_code  (c3),
        .therm    (th3),
        .level    (lv3),
        .busy     (busy3),
        .done     (done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        logic [31:0] e;
        rst = 1'b1; v1 = 1'b0; c1 = '0; v3 = 1'b0; c3 = '0; ab1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_therm", 32'(th1), 32'h0);
        chk("rst_level", 32'(lv1), 32'h0);
        chk("rst_ready", 32'(rdy1), 32'h1);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_therm3", 32'(th3), 32'h0);

        // Up-ramp 0 -> 15, one step per edge.
        v1 = 1'b1; c1 = 4'd15; tick(); v1 = 1'b0;
        chk("up_acc_ready", 32'(rdy1), 32'h0);
        chk("up_acc_busy", 32'(busy1), 32'h1);
        chk("up_acc_therm", 32'(th1), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            e = (32'd1 << k) - 32'd1;
            chk("up_therm", 32'(th1), e);
            chk("up_level", 32'(lv1), 32'(k));
            chk("up_done", 32'(done1), (k == 15) ? 32'h1 : 32'h0);
        end
        chk("up_busy_off", 32'(busy1), 32'h0);
        tick();
        chk("up_done_clr", 32'(done1), 32'h0);
        chk("up_ready_back", 32'(rdy1), 32'h1);

        // Down-ramp 15 -> 3.
        v1 = 1'b1; c1 = 4'd3; tick(); v1 = 1'b0;
        chk("dn_acc_therm", 32'(th1), 32'h7FFF);
        for (int k = 1; k <= 12; k++) begin
            tick();
            e = (32'd1 << (15 - k)) - 32'd1;
            chk("dn_therm", 32'(th1), e);
            chk("dn_done", 32'(done1), (k == 12) ? 32'h1 : 32'h0);
        end
        chk("dn_final_therm", 32'(th1), 32'h0007);
        chk("dn_final_level", 32'(lv1), 32'h3);
        tick();
        chk("dn_ready_back", 32'(rdy1), 32'h1);

        // 3 -> 5 to set up the equal-target case.
        v1 = 1'b1; c1 = 4'd5; tick(); v1 = 1'b0;
        tick(); tick();
        chk("to5_therm", 32'(th1), 32'h001F);
        chk("to5_done", 32'(done1), 32'h1);
        tick();

        // Equal target 5 -> 5.
        v1 = 1'b1; c1 = 4'd5; tick(); v1 = 1'b0;
        chk("eq_done", 32'(done1), 32'h1);
        chk("eq_busy", 32'(busy1), 32'h0);
        chk("eq_therm", 32'(th1), 32'h001F);
        chk("eq_ready_low", 32'(rdy1), 32'h0);
        tick();
        chk("eq_done_clr", 32'(done1), 32'h0);
        chk("eq_ready_back", 32'(rdy1), 32'h1);
        chk("eq_busy2", 32'(busy1), 32'h0);
        chk("eq_therm2", 32'(th1), 32'h001F);

        // Reset mid-ramp at level 7.
        v1 = 1'b1; c1 = 4'd15; tick(); v1 = 1'b0;
        tick(); tick();
        chk("mid_level7", 32'(lv1), 32'h7);
        chk("mid_therm7", 32'(th1), 32'h007F);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_therm", 32'(th1), 32'h0);
        chk("mid_rst_level", 32'(lv1), 32'h0);
        chk("mid_rst_ready", 32'(rdy1), 32'h1);
        chk("mid_rst_busy", 32'(busy1), 32'h0);

`ifdef THERM_ABORT_EN
        // Abort 0 -> 10 after four steps.
        v1 = 1'b1; c1 = 4'd10; tick(); v1 = 1'b0;
        repeat (4) tick();
        chk("ab_pre_therm", 32'(th1), 32'h000F);
        ab1 = 1'b1; tick(); ab1 = 1'b0;
        chk("ab_therm", 32'(th1), 32'h000F);
        chk("ab_level", 32'(lv1), 32'h4);
        chk("ab_ready", 32'(rdy1), 32'h1);
        chk("ab_busy", 32'(busy1), 32'h0);
        chk("ab_done", 32'(done1), 32'h0);
        tick();
        chk("ab_done2", 32'(done1), 32'h0);
        chk("ab_therm2", 32'(th1), 32'h000F);
`endif

        // STEP_CYCLES=3: 0 -> 2.
        v3 = 1'b1; c3 = 4'd2; tick(); v3 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = (i < 3) ? 32'h0 : ((i < 6) ? 32'h1 : 32'h3);
            chk("s3_up2_therm", 32'(th3), e);
        end
        chk("s3_up2_done", 32'(done3), 32'h1);
        tick();
        chk("s3_up2_ready", 32'(rdy3), 32'h1);

        // 2 -> 4 with in_valid held high (code 0) during the ramp.
        v3 = 1'b1; c3 = 4'd4; tick(); c3 = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            e = (i < 3) ? 32'h3 : ((i < 6) ? 32'h7 : 32'hF);
            chk("s3_up4_therm", 32'(th3), e);
            chk("s3_up4_ready", 32'(rdy3), 32'h0);
        end
        chk("s3_up4_done", 32'(done3), 32'h1);
        chk("s3_up4_level", 32'(lv3), 32'h4);
        tick();
        chk("s3_idle_ready", 32'(rdy3), 32'h1);
        chk("s3_idle_therm", 32'(th3), 32'hF);
        chk("s3_idle_busy", 32'(busy3), 32'h0);
        tick();
        chk("s3_reacc_ready", 32'(rdy3), 32'h0);
        chk("s3_reacc_busy", 32'(busy3), 32'h1);
        chk("s3_reacc_therm", 32'(th3), 32'hF);
        v3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done3) seen = 1'b1;
        end
        chk("s3_dn_done_seen", 32'(seen), 32'h1);
        chk("s3_dn_therm", 32'(th3), 32'h0);
        chk("s3_dn_level", 32'(lv3), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
